// File: rtl/etapa_busqueda_if_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel plus
// the valid/ready channel towards decode. The fetch stage is the master.
interface etapa_busqueda_if_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_listo;

    modport master (
        output mem_req, mem_addr, if_valid, if_instr, if_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, id_listo
    );
    modport slave (
        input  mem_req, mem_addr, if_valid, if_instr, if_pc,
        output mem_gnt, mem_rvalid, mem_rdata, id_listo
    );
endinterface

// File: rtl/etapa_busqueda_if.sv
// Instruction-fetch stage: drives the next PC, issues word fetches, buffers
// {pc, instr} in a small FIFO and handles redirects by flushing and
// discarding the responses of fetches already in flight.
// Optional macro ETAPA_BUSQUEDA_CONTADORES_EN adds delivery/bubble counters.
module etapa_busqueda_if #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          PROFUNDIDAD = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         pc_actual,
    output logic [31:0]         pc_siguiente,
    input  logic                salto_valido,
    input  logic [31:0]         salto_destino,
    etapa_busqueda_if_if.master bus,
    output logic                error_alineacion
`ifdef ETAPA_BUSQUEDA_CONTADORES_EN
    ,
    output logic [31:0]         cnt_entregadas,
    output logic [31:0]         cnt_burbujas
`endif
);
    localparam int PW = $clog2(PROFUNDIDAD);
    localparam int CW = $clog2(PROFUNDIDAD + 1);

    typedef enum logic [1:0] {REINICIO, BUSCANDO, DETENIDO} estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] ocup_q, ocup_d, pend_q, pend_d, desc_q, desc_d;
    logic          err_q, err_d;
    logic [PW-1:0] f_wr_q, f_rd_q, p_wr_q, p_rd_q;
    logic [31:0]   fifo_instr_q [PROFUNDIDAD];
    logic [31:0]   fifo_pc_q    [PROFUNDIDAD];
    logic [31:0]   pcq_q        [PROFUNDIDAD];

    logic          req, issue, push, pop, flush;
    logic          resp_util, resp_desc;
    logic [CW:0]   credito;

    // Older (discarded) responses always come first because memory is in order.
    assign resp_desc = bus.mem_rvalid && (desc_q != '0);
    assign resp_util = bus.mem_rvalid && (desc_q == '0) && (pend_q != '0);
    assign credito   = {1'b0, ocup_q} + {1'b0, pend_q};

    // Next-state, request, next-PC and credit bookkeeping
    always_comb begin
        estado_d     = estado_q;
        err_d        = err_q;
        pend_d       = pend_q;
        desc_d       = desc_q;
        req          = 1'b0;
        issue        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        pc_siguiente = pc_actual;
        case (estado_q)
            REINICIO: begin
                pc_siguiente = PC_RESET;
                estado_d     = BUSCANDO;
            end
            BUSCANDO: begin
                if (salto_valido) begin
                    // Everything still in flight becomes a discard credit.
                    flush  = 1'b1;
                    desc_d = desc_q + pend_q
                           - CW'(bus.mem_rvalid && ((desc_q != '0) || (pend_q != '0)));
                    pend_d = '0;
                    if (salto_destino[1:0] != 2'b00) begin
                        // Never load a misaligned PC; freeze instead.
                        err_d    = 1'b1;
                        estado_d = DETENIDO;
                    end else begin
                        pc_siguiente = salto_destino;
                    end
                end else begin
                    req          = credito < (CW+1)'(PROFUNDIDAD);
                    issue        = req && bus.mem_gnt;
                    pc_siguiente = issue ? pc_actual + 32'd4 : pc_actual;
                    pop          = (ocup_q != '0) && bus.id_listo;
                    push         = resp_util;
                    if (resp_desc) desc_d = desc_q - CW'(1);
                    pend_d = pend_q + CW'(issue) - CW'(push);
                end
            end
            DETENIDO: begin
                if (resp_desc) desc_d = desc_q - CW'(1);
            end
            default: estado_d = REINICIO;
        endcase
        ocup_d = flush ? '0 : ocup_q + CW'(push) - CW'(pop);
    end

    // Control state, sticky error and credit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REINICIO;
            err_q    <= 1'b0;
            ocup_q   <= '0;
            pend_q   <= '0;
            desc_q   <= '0;
        end else begin
            estado_q <= estado_d;
            err_q    <= err_d;
            ocup_q   <= ocup_d;
            pend_q   <= pend_d;
            desc_q   <= desc_d;
        end
    end

    // Pointers of the issue-time PC queue; a flush drops all live entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_wr_q <= '0;
            p_rd_q <= '0;
        end else if (flush) begin
            p_wr_q <= '0;
            p_rd_q <= '0;
        end else begin
            if (issue) p_wr_q <= p_wr_q + PW'(1);
            if (push)  p_rd_q <= p_rd_q + PW'(1);
        end
    end

    // PC queue storage: address recorded when the fetch is granted
    always_ff @(posedge clk) begin
        if (issue) pcq_q[p_wr_q] <= pc_actual;
    end

    // Instruction FIFO towards decode; cleared on reset so the head reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wr_q <= '0;
            f_rd_q <= '0;
            for (int i = 0; i < PROFUNDIDAD; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (flush) begin
            f_wr_q <= '0;
            f_rd_q <= '0;
        end else begin
            if (push) begin
                fifo_instr_q[f_wr_q] <= bus.mem_rdata;
                fifo_pc_q[f_wr_q]    <= pcq_q[p_rd_q];
                f_wr_q               <= f_wr_q + PW'(1);
            end
            if (pop) f_rd_q <= f_rd_q + PW'(1);
        end
    end

    assign bus.mem_req     = req;
    assign bus.mem_addr    = pc_actual;
    assign bus.if_valid    = (ocup_q != '0);
    assign bus.if_instr    = fifo_instr_q[f_rd_q];
    assign bus.if_pc       = fifo_pc_q[f_rd_q];
    assign error_alineacion = err_q;

`ifdef ETAPA_BUSQUEDA_CONTADORES_EN
    logic [31:0] cnt_ent_q, cnt_bur_q;

    // Delivered instructions and fetching cycles with nothing to hand to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ent_q <= '0;
            cnt_bur_q <= '0;
        end else begin
            if (pop) cnt_ent_q <= cnt_ent_q + 32'd1;
            if ((estado_q == BUSCANDO) && (ocup_q == '0)) cnt_bur_q <= cnt_bur_q + 32'd1;
        end
    end

    assign cnt_entregadas = cnt_ent_q;
    assign cnt_burbujas   = cnt_bur_q;
`endif

endmodule

// File: tb/tb_etapa_busqueda_if.sv
// Bench for etapa_busqueda_if: in-order memory model with programmable
// latency, a PC register model, and a scoreboard of expected {pc, instr}
// pushed at grant time and popped when decode accepts.
module tb_etapa_busqueda_if;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam int          PROF     = 2;
    localparam logic [31:0] PATRON   = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_actual, pc_siguiente, salto_destino;
    logic        salto_valido, error_alineacion;
`ifdef ETAPA_BUSQUEDA_CONTADORES_EN
    logic [31:0] cnt_entregadas, cnt_burbujas;
`endif

    etapa_busqueda_if_if bus();

    always #5 clk = ~clk;

    etapa_busqueda_if #(.PC_RESET(PC_RESET), .PROFUNDIDAD(PROF)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_actual       (pc_actual),
        .pc_siguiente    (pc_siguiente),
        .salto_valido    (salto_valido),
        .salto_destino   (salto_destino),
        .bus             (bus),
        .error_alineacion(error_alineacion)
`ifdef ETAPA_BUSQUEDA_CONTADORES_EN
        ,
        .cnt_entregadas  (cnt_entregadas),
        .cnt_burbujas    (cnt_burbujas)
`endif
    );

    typedef struct { int due; logic [31:0] addr; } resp_t;

    resp_t       mq[$];
    logic [63:0] sb[$];
    int          cyc, cyc_rel, lat, last_due, n_vec, n_err, pops, first_v, p0;
    logic [31:0] exp_pc, pc_sig_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock: monitor at negedge, then advance PC register and memory model.
    task automatic tick();
        logic [63:0] e;
        resp_t       r;
        int          due;
        @(negedge clk);
        if (rst_n) begin
            if (first_v < 0 && bus.if_valid) first_v = cyc - cyc_rel;
            if (salto_valido) begin
                sb.delete();
                if (salto_destino[1:0] == 2'b00) exp_pc = salto_destino;
            end else begin
                if (bus.if_valid && bus.id_listo) begin
                    pops++;
                    if (sb.size() == 0) chk("sb_vacio", 32'(sb.size()), 32'd1);
                    else begin
                        e = sb.pop_front();
                        chk("if_pc", bus.if_pc, e[63:32]);
                        chk("if_instr", bus.if_instr, e[31:0]);
                    end
                end
                if (bus.mem_req && bus.mem_gnt) begin
                    chk("mem_addr", bus.mem_addr, exp_pc);
                    chk("pc_sig", pc_siguiente, exp_pc + 32'd4);
                    if (exp_pc == 32'hFFFF_FFFC) chk("pc_wrap", pc_siguiente, 32'h0);
                    sb.push_back({exp_pc, exp_pc ^ PATRON});
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mq.push_back('{due, bus.mem_addr});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        pc_sig_s = pc_siguiente;
        @(posedge clk);
        #1;
        cyc++;
        pc_actual = rst_n ? pc_sig_s : PC_RESET;
        bus.mem_rvalid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = r.addr ^ PATRON;
        end
    endtask

    task automatic saltar(input logic [31:0] destino);
        salto_valido  = 1'b1;
        salto_destino = destino;
        tick();
        salto_valido  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; pops = 0; first_v = -1;
        cyc = 0; cyc_rel = 0; lat = 1; last_due = 0;
        exp_pc = PC_RESET; pc_actual = PC_RESET; pc_sig_s = PC_RESET;
        salto_valido = 1'b0; salto_destino = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.id_listo = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_pc_sig", pc_siguiente, PC_RESET);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_vld", bus.if_valid, 0);
        chk("rst_instr", bus.if_instr, 0);
        chk("rst_pc", bus.if_pc, 0);
        chk("rst_err", error_alineacion, 0);
`ifdef ETAPA_BUSQUEDA_CONTADORES_EN
        chk("rst_cnt_ent", cnt_entregadas, 0);
        chk("rst_cnt_bur", cnt_burbujas, 0);
`endif

        // Streaming fetch with single-cycle memory
        bus.mem_gnt = 1'b1; bus.id_listo = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; cyc_rel = cyc;
        #2;
        chk("reinicio_req", bus.mem_req, 0);
        chk("reinicio_pc", pc_siguiente, PC_RESET);
        repeat (10) tick();
        chk("lat_primera", 32'(first_v), 32'd3);

        // Decode stall: FIFO fills, fetch stops, PC holds
        bus.id_listo = 1'b0;
        repeat (6) tick();
        #2;
        chk("stall_req", bus.mem_req, 0);
        chk("stall_pc", pc_siguiente, pc_actual);
        chk("stall_vld", bus.if_valid, 1);
        bus.id_listo = 1'b1;
        repeat (8) tick();

        // Redirect with fetches in flight
        lat = 3;
        repeat (3) tick();
        saltar(32'h0000_0100);
        #2;
        chk("flush_vld", bus.if_valid, 0);
        lat = 1;
        p0 = pops;
        repeat (12) tick();
        chk("entregas_salto", 32'(pops - p0 >= 2), 32'd1);

        // PC wrap at the top of the address space
        saltar(32'hFFFF_FFFC);
        repeat (8) tick();

        // Misaligned redirect freezes the stage until reset
        saltar(32'h0000_0102);
        repeat (5) tick();
        #2;
        chk("err_set", error_alineacion, 1);
        chk("err_req", bus.mem_req, 0);
        chk("err_pc", pc_siguiente, pc_actual);
        chk("err_vld", bus.if_valid, 0);
        rst_n = 1'b0;
        sb.delete(); exp_pc = PC_RESET;
        #2;
        chk("err_clr", error_alineacion, 0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();

        // Reset with fetches outstanding; late responses must be ignored
        lat = 4;
        repeat (3) tick();
        rst_n = 1'b0;
        sb.delete(); exp_pc = PC_RESET;
        bus.mem_gnt = 1'b0;
        #2;
`ifdef ETAPA_BUSQUEDA_CONTADORES_EN
        chk("rst2_cnt_ent", cnt_entregadas, 0);
`endif
        tick();
        rst_n = 1'b1;
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            #2;
            chk("espurio_vld", bus.if_valid, 0);
        end
        bus.mem_gnt = 1'b1; lat = 1;
        for (int i = 0; i < 80 && pops < 10; i++) tick();
        chk("entregas", 32'(pops), 32'd10);
`ifdef ETAPA_BUSQUEDA_CONTADORES_EN
        #2;
        chk("cnt_entregadas", cnt_entregadas, 32'(pops));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
